reset_seq: RTL and testbench

- Parametrised power-on/reset sequencer; successor to the fixed-width DCLO/ACLO generator.
- Merges N asynchronous reset requests with PLL lock and produces the CPU DCLO/ACLO pair plus N_DOM staggered peripheral domain resets.
- Classifies each reset as cold or warm from hold time, PLL loss or configuration change, and latches the requesting sources.
- Sits between the MIST I/O, PLL and the vm1_wb/peripheral reset inputs; replaces ad-hoc cold_start logic in the top level.

---
 rtl/reset_seq_pkg.sv | 22 ++
 rtl/sync_bit.sv | 23 ++
 rtl/reset_seq.sv | 170 +++++++++++++++++
 tb/tb_reset_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and width helpers for the reset sequencer.
package reset_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        DCLO,
        ACLO,
        STAG,
        RUN
    } state_t;

    function automatic int cnt_w(input int x);
        return $clog2(x + 1);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for one asynchronous level, cleared to 0 on reset.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ff <= '0;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/reset_seq.sv
// Power-on/reset sequencer: DCLO/ACLO generation, staggered domain
// releases and cold/warm classification of each reset request.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int N_SRC       = 4,
    parameter int N_DOM       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int DCLO_CLK    = 24,
    parameter int ACLO_CLK    = 240,
    parameter int STAGGER_CLK = 64,
    parameter int COLD_CLK    = 3000000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N_SRC-1:0] src,
    input  logic             plock,
    input  logic             cfg_change,
    output logic             dclo,
    output logic             aclo,
    output logic [N_DOM-1:0] dom_rst,
    output logic             cold_start,
    output logic [N_SRC-1:0] cause,
    output logic             busy
);

    localparam int HW = cnt_w(COLD_CLK);
    localparam int CW = cnt_w(max3(DCLO_CLK, ACLO_CLK, STAGGER_CLK));
    localparam int DW = (N_DOM > 1) ? $clog2(N_DOM) : 1;

    localparam logic [HW-1:0]    COLD_T = HW'(COLD_CLK);
    localparam logic [CW-1:0]    DCLO_T = CW'(DCLO_CLK - 1);
    localparam logic [CW-1:0]    ACLO_T = CW'(ACLO_CLK - 1);
    localparam logic [CW-1:0]    STAG_T = CW'(STAGGER_CLK - 1);
    localparam logic [DW-1:0]    LAST   = DW'(N_DOM - 1);
    localparam logic [N_DOM-1:0] ONE    = N_DOM'(1);

    logic [N_SRC-1:0] src_s;
    logic             plock_s;
    logic             req;

    state_t           state;
    logic [HW-1:0]    hold_cnt;
    logic [CW-1:0]    cnt;
    logic [DW-1:0]    dom_idx;
    logic             plock_lost;
    logic             cfg_dirty;

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        sync_bit #(.STAGES(SYNC_STAGES)) u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (src[i]),
            .q       (src_s[i])
        );
    end

    sync_bit #(.STAGES(SYNC_STAGES)) u_plock (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (plock),
        .q       (plock_s)
    );

    assign req = (|src_s) | ~plock_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= HOLD;
            dclo       <= 1'b1;
            aclo       <= 1'b1;
            dom_rst    <= '1;
            busy       <= 1'b1;
            cold_start <= 1'b1;
            cause      <= '0;
            hold_cnt   <= '0;
            cnt        <= '0;
            dom_idx    <= '0;
            plock_lost <= 1'b0;
            cfg_dirty  <= 1'b0;
        end else begin
            if (cfg_change) begin
                cfg_dirty <= 1'b1;
            end
            if (state != HOLD && req) begin
                // any new request restarts the whole sequence
                state    <= HOLD;
                dclo     <= 1'b1;
                aclo     <= 1'b1;
                dom_rst  <= '1;
                busy     <= 1'b1;
                cnt      <= '0;
                hold_cnt <= '0;
                dom_idx  <= '0;
                cause    <= src_s;
                if (!plock_s) begin
                    plock_lost <= 1'b1;
                end
            end else begin
                unique case (state)
                    HOLD: begin
                        if (req) begin
                            if (hold_cnt != COLD_T) begin
                                hold_cnt <= hold_cnt + HW'(1);
                            end
                            cause <= cause | src_s;
                            if (!plock_s) begin
                                plock_lost <= 1'b1;
                            end
                        end else begin
                            state      <= DCLO;
                            cnt        <= '0;
                            hold_cnt   <= '0;
                            cold_start <= (hold_cnt >= COLD_T) | plock_lost
                                        | cfg_dirty | cfg_change;
                            cfg_dirty  <= 1'b0;
                            plock_lost <= 1'b0;
                        end
                    end
                    DCLO: begin
                        if (cnt == DCLO_T) begin
                            dclo  <= 1'b0;
                            cnt   <= '0;
                            state <= ACLO;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    ACLO: begin
                        if (cnt == ACLO_T) begin
                            aclo       <= 1'b0;
                            dom_rst[0] <= 1'b0;
                            cnt        <= '0;
                            dom_idx    <= DW'(1);
                            if (N_DOM == 1) begin
                                busy  <= 1'b0;
                                state <= RUN;
                            end else begin
                                state <= STAG;
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STAG: begin
                        if (cnt == STAG_T) begin
                            cnt     <= '0;
                            dom_rst <= dom_rst & ~(ONE << dom_idx);
                            if (dom_idx == LAST) begin
                                busy  <= 1'b0;
                                state <= RUN;
                            end else begin
                                dom_idx <= dom_idx + DW'(1);
                            end
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    RUN: begin
                        state <= RUN;
                    end
                    default: begin
                        state <= HOLD;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_reset_seq.sv
// Scoreboard bench for reset_seq: expected output changes are queued
// with their clock number and a monitor pops them as the outputs move.
module tb_reset_seq;

    localparam int BIG = 1 << 30;

    typedef struct packed {
        logic       dclo;
        logic       aclo;
        logic [2:0] dom;
        logic       busy;
        logic       cold;
        logic [3:0] cause;
    } snap_t;

    typedef struct {
        int    c;
        snap_t s;
    } ev_t;

    localparam snap_t RST = '{1'b1, 1'b1, 3'b111, 1'b1, 1'b1, 4'b0000};

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] src;
    logic       plock;
    logic       cfg_change;
    logic       dclo;
    logic       aclo;
    logic [2:0] dom_rst;
    logic       cold_start;
    logic [3:0] cause;
    logic       busy;

    int    cyc = 0;
    int    checks = 0;
    int    failures = 0;
    ev_t   q[$];
    logic  e_cold = 1'b1;
    logic [3:0] e_cause = 4'b0000;
    snap_t prev = RST;
    snap_t cur;
    ev_t   ev;

    always #5 clk = ~clk;

    reset_seq #(
        .N_SRC       (4),
        .N_DOM       (3),
        .SYNC_STAGES (2),
        .DCLO_CLK    (4),
        .ACLO_CLK    (8),
        .STAGGER_CLK (3),
        .COLD_CLK    (20)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .src        (src),
        .plock      (plock),
        .cfg_change (cfg_change),
        .dclo       (dclo),
        .aclo       (aclo),
        .dom_rst    (dom_rst),
        .cold_start (cold_start),
        .cause      (cause),
        .busy       (busy)
    );

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= 0;
        else          cyc <= cyc + 1;
    end

    function automatic snap_t now_snap();
        snap_t s;
        s = '{dclo, aclo, dom_rst, busy, cold_start, cause};
        return s;
    endfunction

    always @(posedge clk) begin
        #1;
        cur = now_snap();
        if (reset_n === 1'b1 && cur !== prev) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got=%b", cyc, cur);
            end else begin
                ev = q.pop_front();
                if (ev.c != cyc || cur !== ev.s) begin
                    failures++;
                    $display("FAIL event got cyc=%0d snap=%b required cyc=%0d snap=%b",
                             cyc, cur, ev.c, ev.s);
                end
            end
        end
        prev = cur;
    end

    task automatic push(input int c, input logic d, input logic a,
                        input logic [2:0] dm, input logic b);
        ev_t e;
        e.c = c;
        e.s = '{d, a, dm, b, e_cold, e_cause};
        q.push_back(e);
    endtask

    task automatic push_hold(input int c, input logic [3:0] cs);
        e_cause = cs;
        push(c, 1'b1, 1'b1, 3'b111, 1'b1);
    endtask

    task automatic push_seq(input int x, input logic nc, input int upto);
        if (nc !== e_cold) begin
            e_cold = nc;
            if (x < upto) push(x, 1'b1, 1'b1, 3'b111, 1'b1);
        end
        if (x + 4 < upto)  push(x + 4,  1'b0, 1'b1, 3'b111, 1'b1);
        if (x + 12 < upto) push(x + 12, 1'b0, 1'b0, 3'b110, 1'b1);
        if (x + 15 < upto) push(x + 15, 1'b0, 1'b0, 3'b100, 1'b1);
        if (x + 18 < upto) push(x + 18, 1'b0, 1'b0, 3'b000, 1'b0);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_snap(input string name, input snap_t exp);
        snap_t s;
        s = now_snap();
        checks++;
        if (s !== exp) begin
            failures++;
            $display("FAIL %s got=%b required=%b", name, s, exp);
        end
    endtask

    task automatic check_empty(input string name);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL %s pending got=%0d required=0", name, q.size());
        end
    endtask

    task automatic pulse_src(input logic [3:0] v, input int len, input logic nc);
        int t;
        t = cyc;
        src = v;
        push_hold(t + 3, v);
        wait_n(len);
        src = '0;
        push_seq(t + len + 3, nc, BIG);
    endtask

    initial begin
        int t;
        int x;
        reset_n = 1'b0;
        src = '0;
        plock = 1'b1;
        cfg_change = 1'b0;
        wait_n(3);
        check_snap("reset_values", RST);

        // power-on
        reset_n = 1'b1;
        push_seq(3, 1'b1, BIG);
        wait_n(25);

        // short src[1] request: warm
        pulse_src(4'b0010, 5, 1'b0);
        wait_n(25);

        // long src[0] request: cold, then src[2] during ACLO restarts it
        t = cyc;
        src = 4'b0001;
        push_hold(t + 3, 4'b0001);
        wait_n(25);
        src = '0;
        x = t + 28;
        push_seq(x, 1'b1, x + 9);
        wait_n(9);
        t = cyc;
        src = 4'b0100;
        push_hold(t + 3, 4'b0100);
        wait_n(3);
        src = '0;
        push_seq(t + 6, 1'b0, BIG);
        wait_n(25);

        // configuration change makes the next reset cold, only once
        cfg_change = 1'b1;
        wait_n(1);
        cfg_change = 1'b0;
        wait_n(2);
        pulse_src(4'b1000, 5, 1'b1);
        wait_n(25);
        pulse_src(4'b1000, 5, 1'b0);
        wait_n(25);

        // PLL loss, then async reset during STAG
        t = cyc;
        plock = 1'b0;
        push_hold(t + 3, 4'b0000);
        wait_n(4);
        plock = 1'b1;
        x = t + 7;
        push_seq(x, 1'b1, x + 14);
        wait_n(17);
        reset_n = 1'b0;
        #1;
        check_snap("async_reset", RST);
        check_empty("queue_mid");
        wait_n(3);
        e_cold = 1'b1;
        e_cause = 4'b0000;
        reset_n = 1'b1;
        push_seq(3, 1'b1, BIG);
        wait_n(25);
        check_empty("queue_end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
